// File: rtl/sift_desc_pkg.sv
// Shared constants and FSM state type for the SIFT descriptor grid scan.
// Used by the descriptor sample sequencer.
package sift_desc_pkg;

    localparam int GRID_N       = 16;
    localparam int GRID_SAMPLES = GRID_N * GRID_N;
    localparam int ROT_W        = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LAST
    } scan_state_e;

endpackage

// File: rtl/desc_rot_scan.sv
// Walks the 16x16 descriptor grid of one keypoint and streams rotated
// absolute sample coordinates with in-bounds flags over valid/ready.
module desc_rot_scan
    import sift_desc_pkg::*;
#(
    parameter int PW    = 11,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PW-1:0]    kp_x,
    input  logic [PW-1:0]    kp_y,
    output logic             busy,
    output logic [7:0]       rom_a,
    input  logic [ROT_W-1:0] rom_dx,
    input  logic [ROT_W-1:0] rom_dy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_x,
    output logic [PW-1:0]    out_y,
    output logic [7:0]       out_idx,
    output logic             out_inb,
    output logic             done
);

    scan_state_e state, state_nx;

    logic [7:0]     cnt;
    logic [PW-1:0]  kx;
    logic [PW-1:0]  ky;
    logic signed [PW:0] sx;
    logic signed [PW:0] sy;
    logic           ld;
    logic           cnt_last;
    logic           x_ok;
    logic           y_ok;

    assign ld       = !out_valid || out_ready;
    assign cnt_last = (cnt == 8'(GRID_SAMPLES - 1));
    assign rom_a    = (state == IDLE) ? 8'd0 : cnt;

    // Offsets are sign-extended into one extra bit so negatives stay visible.
    assign sx = $signed({1'b0, kx})
              + $signed({{(PW + 1 - ROT_W){rom_dx[ROT_W-1]}}, rom_dx});
    assign sy = $signed({1'b0, ky})
              + $signed({{(PW + 1 - ROT_W){rom_dy[ROT_W-1]}}, rom_dy});

    assign x_ok = !sx[PW] && (sx[PW-1:0] < PW'(IMG_W));
    assign y_ok = !sy[PW] && (sy[PW-1:0] < PW'(IMG_H));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = RUN;
            RUN:  if (ld && cnt_last) state_nx = LAST;
            LAST: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            kx        <= '0;
            ky        <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_idx   <= '0;
            out_inb   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        kx   <= kp_x;
                        ky   <= kp_y;
                        cnt  <= '0;
                        busy <= 1'b1;
                    end
                end
                RUN: begin
                    if (ld) begin
                        out_x     <= sx[PW-1:0];
                        out_y     <= sy[PW-1:0];
                        out_idx   <= cnt;
                        out_inb   <= x_ok && y_ok;
                        out_valid <= 1'b1;
                        if (!cnt_last) cnt <= cnt + 8'd1;
                    end
                end
                LAST: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_desc_rot_scan.sv
// Directed bench for desc_rot_scan with a behavioural rotation ROM pair.
// Expected coordinates come from integer arithmetic on the ROM model.
module tb_desc_rot_scan;

    localparam int PW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [PW-1:0] kp_x;
    logic [PW-1:0] kp_y;
    logic          busy;
    logic [7:0]    rom_a;
    logic [4:0]    rom_dx;
    logic [4:0]    rom_dy;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_x;
    logic [PW-1:0] out_y;
    logic [7:0]    out_idx;
    logic          out_inb;
    logic          done;

    int errors = 0;
    int checks = 0;
    int n_hs;
    int n_done;
    int done_k;
    int n_inb;

    logic [PW-1:0] cap_x [256];
    logic [PW-1:0] cap_y [256];
    logic          cap_inb [256];

    always #5 clk = ~clk;

    desc_rot_scan #(.PW(PW), .IMG_W(640), .IMG_H(480)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .kp_x(kp_x),
        .kp_y(kp_y),
        .busy(busy),
        .rom_a(rom_a),
        .rom_dx(rom_dx),
        .rom_dy(rom_dy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x(out_x),
        .out_y(out_y),
        .out_idx(out_idx),
        .out_inb(out_inb),
        .done(done)
    );

    function automatic int dxf(input logic [7:0] a);
        if (a == 8'd0) return 5;
        if (a == 8'd96) return -1;
        if (a == 8'd240) return -9;
        return int'(a[3:0]) - 8;
    endfunction

    function automatic int dyf(input logic [7:0] a);
        if (a == 8'd0) return 5;
        return int'(a[7:4]) - 8;
    endfunction

    always_comb begin
        rom_dx = 5'(dxf(rom_a));
        rom_dy = 5'(dyf(rom_a));
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic scan(input int kx, input int ky, input bit rnd,
                        input bit spam, input int abort_k);
        int k;
        int sx;
        int sy;
        bit rdy;
        bit stalled;
        logic [PW-1:0] hx;
        logic [PW-1:0] hy;
        logic [7:0] hi;
        logic hinb;
        n_hs = 0;
        n_done = 0;
        done_k = -1;
        n_inb = 0;
        stalled = 1'b0;
        hx = '0;
        hy = '0;
        hi = '0;
        hinb = 1'b0;
        k = 0;
        @(negedge clk);
        kp_x = PW'(kx);
        kp_y = PW'(ky);
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("valid_at_start", out_valid, 0);
        while (k < 3000) begin
            if (abort_k >= 0 && k == abort_k) begin
                start = 1'b0;
                return;
            end
            if (done) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k >= done_k + 4) break;
            if (k == 1) chk("valid_latency", out_valid, 1);
            if (stalled) begin
                chk("stall_x", out_x, hx);
                chk("stall_y", out_y, hy);
                chk("stall_idx", out_idx, hi);
                chk("stall_inb", out_inb, hinb);
                chk("stall_valid", out_valid, 1);
            end
            rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            out_ready = rdy;
            start = spam && ((k == 10) ||
                    (out_valid && rdy && out_idx == 8'd255));
            if (out_valid && rdy) begin
                sx = kx + dxf(8'(n_hs));
                sy = ky + dyf(8'(n_hs));
                chk("hs_idx", out_idx, n_hs);
                chk("hs_x", out_x, sx & 2047);
                chk("hs_y", out_y, sy & 2047);
                chk("hs_inb", out_inb,
                    (sx >= 0 && sx < 640 && sy >= 0 && sy < 480));
                if (n_hs < 256) begin
                    cap_x[n_hs] = out_x;
                    cap_y[n_hs] = out_y;
                    cap_inb[n_hs] = out_inb;
                end
                if (out_inb) n_inb++;
                n_hs++;
            end
            stalled = out_valid && !rdy;
            hx = out_x;
            hy = out_y;
            hi = out_idx;
            hinb = out_inb;
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk("done_seen", done_k >= 0, 1);
        chk("hs_count", n_hs, 256);
        chk("done_pulses", n_done, 1);
        chk("busy_end", busy, 0);
        chk("valid_end", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        kp_x = '0;
        kp_y = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_rom_a", rom_a, 0);
        chk("rst_done", done, 0);
        chk("rst_x", out_x, 0);
        chk("rst_y", out_y, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_inb", out_inb, 0);
        rst = 1'b0;
        @(negedge clk);

        scan(100, 100, 1'b0, 1'b0, -1);
        chk("done_latency", done_k, 257);
        chk("kp100_x0", cap_x[0], 105);
        chk("kp100_y0", cap_y[0], 105);
        chk("kp100_x96", cap_x[96], 99);
        chk("kp100_y96", cap_y[96], 98);
        chk("kp100_x240", cap_x[240], 91);
        chk("kp100_y240", cap_y[240], 107);
        chk("kp100_all_inb", n_inb, 256);

        scan(0, 0, 1'b0, 1'b0, -1);
        chk("kp0_x96", cap_x[96], 2047);
        chk("kp0_inb96", cap_inb[96], 0);

        scan(639, 0, 1'b0, 1'b0, -1);
        chk("kp639_x9", cap_x[9], 640);
        chk("kp639_inb9", cap_inb[9], 0);
        chk("kp639_x136", cap_x[136], 639);
        chk("kp639_y136", cap_y[136], 0);
        chk("kp639_inb136", cap_inb[136], 1);

        scan(320, 240, 1'b1, 1'b1, -1);

        scan(100, 100, 1'b0, 1'b0, 37);
        chk("mid_rom_a", rom_a, 37);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_rom_a", rom_a, 0);
        chk("arst_done", done, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) n_done++;
        end
        chk("arst_no_done", n_done, 0);
        chk("arst_idle_busy", busy, 0);
        chk("arst_idle_valid", out_valid, 0);

        scan(5, 470, 1'b0, 1'b0, -1);
        chk("recover_latency", done_k, 257);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
